// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sequencer: FSM state encoding,
// default tap count and the word-to-byte address shift.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WAIT_IN,
        MAC,
        OUT,
        DONE
    } fir_state_t;

    localparam int TAPE_NUM_DEF = 11;
    localparam int TAP_IDX_W    = $clog2(TAPE_NUM_DEF);
    localparam int ADDR_SHIFT   = 2;

endpackage

// File: rtl/fir_ring_addr.sv
// Circular-buffer write pointer plus modulo subtractor giving the data-RAM
// index of x[n-k] for the current write pointer.
module fir_ring_addr
    import fir_pkg::*;
#(
    parameter  int Tape_Num = TAPE_NUM_DEF,
    localparam int IDX_W    = $clog2(Tape_Num)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [IDX_W-1:0] i_k,
    output logic [IDX_W-1:0] o_rd_idx
);

    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(Tape_Num - 1);

    logic [IDX_W-1:0] r_wr_ptr;
    logic [IDX_W:0]   w_diff;
    logic [IDX_W:0]   w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
        end else if (i_adv) begin
            r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    // A borrow out of the subtraction means k > wr_ptr: fold back by Tape_Num.
    assign w_diff   = {1'b0, r_wr_ptr} - {1'b0, i_k};
    assign w_wrap   = w_diff + (IDX_W + 1)'(Tape_Num);
    assign o_rd_idx = w_diff[IDX_W] ? w_wrap[IDX_W-1:0] : w_diff[IDX_W-1:0];

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: ap_start/ap_done/ap_idle protocol, ss/sm stream handshakes
// and the tap-RAM / data-RAM address schedule feeding the MAC unit.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = TAPE_NUM_DEF
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   cfg_start,
    input  logic [pDATA_WIDTH-1:0] cfg_len,
    input  logic                   cfg_done_clr,
    output logic                   ap_idle,
    output logic                   ap_done,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   data_we,
    output logic [pADDR_WIDTH-1:0] data_addr,
    output logic [pADDR_WIDTH-1:0] tap_addr,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic                   sm_tlast,
    output logic                   err_tlast
);

    localparam int IDX_W = $clog2(Tape_Num);
    localparam int CNT_W = $clog2(Tape_Num + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(Tape_Num - 1);
    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(Tape_Num);

    fir_state_t             r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [pDATA_WIDTH-1:0] r_len, w_len_next;
    logic [pDATA_WIDTH-1:0] r_sample_cnt, w_sample_cnt_next;
    logic                   r_ap_done, w_ap_done_next;
    logic                   r_err_tlast, w_err_tlast_next;
    logic                   r_mac_en, r_mac_clr;

    logic                   w_issue, w_issue_first;
    logic                   w_ptr_clr, w_ptr_adv;
    logic [IDX_W-1:0]       w_k, w_rd_idx;
    logic [IDX_W-1:0]       w_data_idx, w_tap_idx;

    fir_ring_addr #(
        .Tape_Num (Tape_Num)
    ) u_ring (
        .clk      (axis_clk),
        .rst_n    (axis_rst_n),
        .i_clr    (w_ptr_clr),
        .i_adv    (w_ptr_adv),
        .i_k      (w_k),
        .o_rd_idx (w_rd_idx)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_sample_cnt <= '0;
            r_ap_done    <= 1'b0;
            r_err_tlast  <= 1'b0;
            r_mac_en     <= 1'b0;
            r_mac_clr    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_len        <= w_len_next;
            r_sample_cnt <= w_sample_cnt_next;
            r_ap_done    <= w_ap_done_next;
            r_err_tlast  <= w_err_tlast_next;
            r_mac_en     <= w_issue;
            r_mac_clr    <= w_issue_first;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_len_next        = r_len;
        w_sample_cnt_next = r_sample_cnt;
        w_ap_done_next    = r_ap_done;
        w_err_tlast_next  = r_err_tlast;
        w_issue           = 1'b0;
        w_issue_first     = 1'b0;
        w_ptr_clr         = 1'b0;
        w_ptr_adv         = 1'b0;
        w_k               = '0;
        w_data_idx        = '0;
        w_tap_idx         = '0;
        ap_idle           = 1'b0;
        ss_tready         = 1'b0;
        data_we           = 1'b0;
        sm_tvalid         = 1'b0;
        sm_tlast          = 1'b0;

        if (cfg_done_clr) begin
            w_ap_done_next = 1'b0;
        end

        case (r_state)
            IDLE, DONE: begin
                ap_idle      = 1'b1;
                w_state_next = IDLE;
                // A start in the same cycle as a status read overrides the clear.
                if (cfg_start) begin
                    w_len_next        = cfg_len;
                    w_sample_cnt_next = '0;
                    w_err_tlast_next  = 1'b0;
                    w_cnt_next        = '0;
                    w_ap_done_next    = (cfg_len == '0);
                    w_state_next      = (cfg_len == '0) ? DONE : CLR;
                end
            end
            CLR: begin
                data_we    = 1'b1;
                w_data_idx = r_cnt[IDX_W-1:0];
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_ptr_clr    = 1'b1;
                    w_state_next = WAIT_IN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            WAIT_IN: begin
                ss_tready = ss_tvalid;
                if (ss_tvalid) begin
                    data_we           = 1'b1;
                    w_data_idx        = w_rd_idx;
                    w_sample_cnt_next = r_sample_cnt + pDATA_WIDTH'(1);
                    if (ss_tlast != (r_sample_cnt == (r_len - pDATA_WIDTH'(1)))) begin
                        w_err_tlast_next = 1'b1;
                    end
                    w_cnt_next   = '0;
                    w_state_next = MAC;
                end
            end
            MAC: begin
                // Counts 0..Tape_Num-1 issue reads; the extra count waits out RAM latency.
                if (r_cnt != CNT_DRAIN) begin
                    w_issue       = 1'b1;
                    w_issue_first = (r_cnt == '0);
                    w_k           = r_cnt[IDX_W-1:0];
                    w_tap_idx     = r_cnt[IDX_W-1:0];
                    w_data_idx    = w_rd_idx;
                    w_ptr_adv     = (r_cnt == CNT_LAST);
                    w_cnt_next    = r_cnt + 1'b1;
                end else begin
                    w_cnt_next   = '0;
                    w_state_next = OUT;
                end
            end
            OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = (r_sample_cnt == r_len);
                if (sm_tready) begin
                    if (r_sample_cnt == r_len) begin
                        w_ap_done_next = 1'b1;
                        w_state_next   = DONE;
                    end else begin
                        w_state_next = WAIT_IN;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign data_addr = pADDR_WIDTH'({w_data_idx, {ADDR_SHIFT{1'b0}}});
    assign tap_addr  = pADDR_WIDTH'({w_tap_idx, {ADDR_SHIFT{1'b0}}});
    assign ap_done   = r_ap_done;
    assign err_tlast = r_err_tlast;
    assign mac_en    = r_mac_en;
    assign mac_clr   = r_mac_clr;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl: the driver pushes expected results and MAC
// address pairs as samples are accepted; a monitor pops and compares them.
module tb_fir_seq_ctrl;

    localparam int N  = 11;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [DW-1:0] cfg_len = '0;
    logic          cfg_done_clr = 1'b0;
    logic          ap_idle, ap_done;
    logic          ss_tvalid = 1'b0;
    logic          ss_tlast = 1'b0;
    logic          ss_tready;
    logic          data_we;
    logic [AW-1:0] data_addr, tap_addr;
    logic          mac_clr, mac_en;
    logic          sm_tvalid;
    logic          sm_tready = 1'b0;
    logic          sm_tlast, err_tlast;

    fir_seq_ctrl #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .Tape_Num    (N)
    ) dut (
        .axis_clk     (clk),
        .axis_rst_n   (rst_n),
        .cfg_start    (cfg_start),
        .cfg_len      (cfg_len),
        .cfg_done_clr (cfg_done_clr),
        .ap_idle      (ap_idle),
        .ap_done      (ap_done),
        .ss_tvalid    (ss_tvalid),
        .ss_tlast     (ss_tlast),
        .ss_tready    (ss_tready),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .tap_addr     (tap_addr),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .sm_tvalid    (sm_tvalid),
        .sm_tready    (sm_tready),
        .sm_tlast     (sm_tlast),
        .err_tlast    (err_tlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit tlast; int due; } res_t;
    typedef struct { int tap; int dat; bit clr; } mac_t;
    res_t res_q[$];
    mac_t mac_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mac_cnt  = 0;
    int res_cnt  = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    // Reference model of the current run
    int m_len = 0;
    int m_acc = 0;
    bit m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       sm_tready = 1'b1;
                1:       sm_tready = ($urandom_range(0, 3) != 0);
                default: sm_tready = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        logic [31:0] prev_tap, prev_dat;
        logic        held_tlast;
        bit          in_res;
        mac_t        me;
        res_t        re;
        prev_tap = '0;
        prev_dat = '0;
        held_tlast = 1'b0;
        in_res = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                in_res = 1'b0;
                continue;
            end
            if (mac_en) begin
                mac_cnt++;
                if (mac_q.size() == 0) begin
                    check("mac_unexpected", 32'(mac_en), 0);
                end else begin
                    me = mac_q.pop_front();
                    check("mac_tap_addr", prev_tap, me.tap);
                    check("mac_data_addr", prev_dat, me.dat);
                    check("mac_clr", 32'(mac_clr), 32'(me.clr));
                end
            end
            prev_tap = 32'(tap_addr);
            prev_dat = 32'(data_addr);
            if (sm_tvalid) begin
                check("ss_tready_in_out", 32'(ss_tready), 0);
                if (!in_res) begin
                    in_res = 1'b1;
                    held_tlast = sm_tlast;
                    if (res_q.size() == 0) begin
                        check("result_unexpected", 32'(sm_tvalid), 0);
                    end else begin
                        check("result_latency", cyc, res_q[0].due);
                        check("result_tlast", 32'(sm_tlast), 32'(res_q[0].tlast));
                    end
                end else begin
                    check("sm_tlast_stable", 32'(sm_tlast), 32'(held_tlast));
                end
                if (sm_tready) begin
                    in_res = 1'b0;
                    if (res_q.size() > 0) re = res_q.pop_front();
                    res_cnt++;
                    $display("result %0d tlast=%0d cycle=%0d", res_cnt, sm_tlast, cyc);
                end
            end else if (in_res) begin
                check("sm_tvalid_held", 32'(sm_tvalid), 1);
                in_res = 1'b0;
            end
        end
    end

    task automatic start_run(input int len, input bit with_clr);
        cfg_len = len;
        @(negedge clk);
        cfg_start    = 1'b1;
        cfg_done_clr = with_clr;
        m_len = len;
        m_acc = 0;
        m_err = 1'b0;
        @(negedge clk);
        cfg_start    = 1'b0;
        cfg_done_clr = 1'b0;
        cfg_len      = $urandom;   // must be ignored: length was latched
    endtask

    task automatic send_sample(input bit tl);
        int   w;
        int   ptr;
        mac_t m;
        res_t r;
        w = 0;
        @(negedge clk);
        ss_tvalid = 1'b1;
        ss_tlast  = tl;
        #1;
        while (!ss_tready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!ss_tready) begin
            check("ss_accept_timeout", 32'(ss_tready), 1);
            return;
        end
        m_acc++;
        ptr = (m_acc - 1) % N;
        check("wr_data_we", 32'(data_we), 1);
        check("wr_data_addr", 32'(data_addr), ptr * 4);
        r.tlast = (m_acc == m_len);
        r.due   = cyc + N + 2;
        res_q.push_back(r);
        for (int k = 0; k < N; k++) begin
            m.tap = k * 4;
            m.dat = ((((ptr - k) % N) + N) % N) * 4;
            m.clr = (k == 0);
            mac_q.push_back(m);
        end
        if (tl != (m_acc == m_len)) m_err = 1'b1;
        $display("sample %0d/%0d accepted tlast=%0d ptr=%0d cycle=%0d", m_acc, m_len, tl, ptr, cyc);
    endtask

    task automatic run_stream(input int len, input int flip, input int max_gap);
        int gap;
        bit tl;
        for (int i = 1; i <= len; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                @(negedge clk);
                ss_tvalid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
            tl = (i == len) ^ (i == flip);
            send_sample(tl);
        end
        @(negedge clk);
        ss_tvalid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (ap_done !== 1'b1 && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, "_ap_done"}, 32'(ap_done), 1);
        check({tag, "_ap_idle"}, 32'(ap_idle), 1);
        check({tag, "_err_tlast"}, 32'(err_tlast), 32'(m_err));
        check({tag, "_results_left"}, res_q.size(), 0);
        check({tag, "_mac_left"}, mac_q.size(), 0);
        @(negedge clk);
        cfg_done_clr = 1'b1;
        @(negedge clk);
        cfg_done_clr = 1'b0;
        #1;
        check({tag, "_done_clr"}, 32'(ap_done), 0);
        $display("run %s len=%0d complete", tag, m_len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, flip;

        // Reset state, with a valid sample pending
        ss_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ap_idle", 32'(ap_idle), 1);
        check("rst_ap_done", 32'(ap_done), 0);
        check("rst_ss_tready", 32'(ss_tready), 0);
        check("rst_sm_tvalid", 32'(sm_tvalid), 0);
        check("rst_mac_en", 32'(mac_en), 0);
        check("rst_err_tlast", 32'(err_tlast), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ss_tvalid = 1'b0;
        @(negedge clk);
        #1;
        check("idle_ss_tready", 32'(ss_tready), 0);

        // len=3 back-to-back, always ready
        rdy_mode = 0;
        mac_cnt = 0;
        start_run(3, 1'b0);
        #1;
        check("run_ap_idle_low", 32'(ap_idle), 0);
        run_stream(3, 0, 0);
        wait_done("len3");
        check("len3_mac_en_count", mac_cnt, 33);

        // 12 samples: write pointer wraps
        rdy_mode = 1;
        start_run(12, 1'b0);
        run_stream(12, 0, 0);
        wait_done("len12");

        // Backpressure held for several cycles
        rdy_mode = 2;
        start_run(2, 1'b0);
        fork
            run_stream(2, 0, 0);
            begin
                int w;
                w = 0;
                while (!sm_tvalid && w < 100) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                repeat (5) @(negedge clk);
                rdy_mode = 0;
            end
        join
        wait_done("hold");

        // len=0: done next cycle, nothing consumed
        cfg_len = 0;
        @(negedge clk);
        cfg_start = 1'b1;
        ss_tvalid = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        check("len0_ap_done", 32'(ap_done), 1);
        check("len0_ap_idle", 32'(ap_idle), 1);
        check("len0_ss_tready", 32'(ss_tready), 0);
        @(negedge clk);
        #1;
        check("len0_ss_tready_2", 32'(ss_tready), 0);
        check("len0_ap_done_sticky", 32'(ap_done), 1);
        ss_tvalid = 1'b0;

        // Start together with status clear: start wins
        start_run(1, 1'b1);
        #1;
        check("start_clr_ap_done", 32'(ap_done), 0);
        check("start_clr_ap_idle", 32'(ap_idle), 0);
        run_stream(1, 0, 0);
        wait_done("len1");

        // cfg_start mid-run is ignored
        start_run(3, 1'b0);
        send_sample(1'b0);
        @(negedge clk);
        cfg_len   = 7;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        send_sample(1'b0);
        send_sample(1'b1);
        @(negedge clk);
        ss_tvalid = 1'b0;
        wait_done("restart_ignored");

        // Early tlast on sample 2 of 4
        rdy_mode = 1;
        start_run(4, 1'b0);
        run_stream(4, 2, 0);
        wait_done("early_tlast");

        // Randomised runs
        for (int r = 0; r < 6; r++) begin
            len  = int'($urandom_range(1, 14));
            flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
            start_run(len, 1'b0);
            run_stream(len, flip, 15);
            wait_done($sformatf("rand%0d", r));
        end

        // Asynchronous reset in the middle of MAC
        rdy_mode = 0;
        start_run(5, 1'b0);
        send_sample(1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ap_idle", 32'(ap_idle), 1);
        check("midrst_ap_done", 32'(ap_done), 0);
        check("midrst_ss_tready", 32'(ss_tready), 0);
        check("midrst_sm_tvalid", 32'(sm_tvalid), 0);
        check("midrst_mac_en", 32'(mac_en), 0);
        check("midrst_mac_clr", 32'(mac_clr), 0);
        check("midrst_data_we", 32'(data_we), 0);
        check("midrst_data_addr", 32'(data_addr), 0);
        check("midrst_tap_addr", 32'(tap_addr), 0);
        check("midrst_sm_tlast", 32'(sm_tlast), 0);
        check("midrst_err_tlast", 32'(err_tlast), 0);
        res_q.delete();
        mac_q.delete();
        ss_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operation after the reset
        start_run(2, 1'b0);
        run_stream(2, 0, 0);
        wait_done("post_reset");

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
